axis_vector_serialiser: RTL

AXIS_VECTOR_SERIALISER -- requirements
Module: axis_vector_serialiser

---
 rtl/axis_vector_pkg.sv | 36 +++
 rtl/axis_beat_select.sv | 46 ++++
 rtl/axis_vector_serialiser.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/axis_vector_pkg.sv
// Shared types and helpers for the vector-to-AXI-Stream serialiser.
// Length, beat-count and tkeep rules live here so the datapath and control agree.
package axis_vector_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // A zero or oversized length means "send the whole vector".
    function automatic int eff_len(input int len, input int vec_bytes);
        if ((len == 32'sd0) || (len > vec_bytes)) begin
            return vec_bytes;
        end else begin
            return len;
        end
    endfunction

    function automatic int beat_count(input int leff, input int axis_bytes);
        return (leff + axis_bytes - 32'sd1) / axis_bytes;
    endfunction

    function automatic logic lane_kept(input int leff, input int axis_bytes,
                                       input logic is_last, input int lane);
        int rem;
        int lanes;
        rem   = leff % axis_bytes;
        lanes = (rem == 32'sd0) ? axis_bytes : rem;
        if (!is_last) begin
            return 1'b1;
        end else begin
            return (lane < lanes) ? 1'b1 : 1'b0;
        end
    endfunction

endpackage

// File: rtl/axis_beat_select.sv
// Combinational beat multiplexer: picks the bytes of one output beat from the
// snapshot vector, applies byte order, and derives tkeep/tlast.
module axis_beat_select
    import axis_vector_pkg::*;
#(
    parameter int VEC_BYTES  = 8,
    parameter int AXIS_BYTES = 2,
    parameter int MSB_FIRST  = 0,
    parameter int LEN_W      = 4,
    parameter int BEAT_W     = 2
)(
    input  logic [VEC_BYTES*8-1:0]  vec,
    input  logic [LEN_W-1:0]        leff,
    input  logic [BEAT_W-1:0]       beat,
    output logic [AXIS_BYTES*8-1:0] tdata,
    output logic [AXIS_BYTES-1:0]   tkeep,
    output logic                    tlast
);

    logic last_s;
    int   src_s;

    // Lane-by-lane byte selection; unkept lanes are forced to zero.
    always_comb begin
        last_s = (int'(beat) == (beat_count(int'(leff), AXIS_BYTES) - 32'sd1)) ? 1'b1 : 1'b0;
        tlast  = last_s;
        tkeep  = '0;
        tdata  = '0;
        src_s  = 32'sd0;
        for (int i = 0; i < AXIS_BYTES; i++) begin
            tkeep[i] = lane_kept(int'(leff), AXIS_BYTES, last_s, i);
            src_s    = (int'(beat) * AXIS_BYTES) + i;
            if (MSB_FIRST != 0) begin
                src_s = VEC_BYTES - 32'sd1 - src_s;
            end else begin
                src_s = src_s;
            end
            if (tkeep[i] && (src_s >= 32'sd0) && (src_s < VEC_BYTES)) begin
                tdata[8*i +: 8] = vec[8*src_s +: 8];
            end else begin
                tdata[8*i +: 8] = 8'h00;
            end
        end
    end

endmodule

// File: rtl/axis_vector_serialiser.sv
// Serialises a snapshot of a wide vector into AXI-Stream beats, with optional
// back-to-back frame repetition. Outputs other than load_ready are registered.
module axis_vector_serialiser
    import axis_vector_pkg::*;
#(
    parameter int  VEC_BYTES  = 8,
    parameter int  AXIS_BYTES = 2,
    parameter int  MSB_FIRST  = 0,
    localparam int BEATS_MAX  = (VEC_BYTES + AXIS_BYTES - 1) / AXIS_BYTES,
    localparam int LEN_W      = $clog2(VEC_BYTES + 1),
    localparam int BEAT_W     = (BEATS_MAX > 1) ? $clog2(BEATS_MAX) : 1
)(
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic [VEC_BYTES*8-1:0]  vec,
    input  logic [LEN_W-1:0]        len,
    input  logic                    cont,
    input  logic                    load_valid,
    output logic                    load_ready,
    output logic                    axis_tvalid,
    input  logic                    axis_tready,
    output logic [AXIS_BYTES*8-1:0] axis_tdata,
    output logic [AXIS_BYTES-1:0]   axis_tkeep,
    output logic                    axis_tlast,
    output logic                    busy
);

    state_t                  state_r, state_s;
    logic [BEAT_W-1:0]       beat_r, beat_s;
    logic [VEC_BYTES*8-1:0]  vec_r, vec_s;
    logic [LEN_W-1:0]        leff_r, leff_s;
    logic                    armed_r;
    logic                    load_ready_s;
    logic                    tvalid_s;
    logic                    last_beat_s;
    logic                    tvalid_r, tlast_r, busy_r;
    logic [AXIS_BYTES*8-1:0] tdata_r;
    logic [AXIS_BYTES-1:0]   tkeep_r;
    logic [AXIS_BYTES*8-1:0] sel_tdata_s;
    logic [AXIS_BYTES-1:0]   sel_tkeep_s;
    logic                    sel_tlast_s;

    // armed_r holds off loads on the first edge after reset release.
    assign load_ready_s = ((state_r == ST_IDLE) && armed_r) ? 1'b1 : 1'b0;
    assign last_beat_s  = (int'(beat_r) == (beat_count(int'(leff_r), AXIS_BYTES) - 32'sd1)) ? 1'b1 : 1'b0;

    // Next-state, beat counter and snapshot selection.
    always_comb begin
        state_s  = state_r;
        beat_s   = beat_r;
        vec_s    = vec_r;
        leff_s   = leff_r;
        tvalid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load_valid && load_ready_s) begin
                    vec_s    = vec;
                    leff_s   = LEN_W'(eff_len(int'(len), VEC_BYTES));
                    beat_s   = '0;
                    state_s  = ST_SEND;
                    tvalid_s = 1'b1;
                end else begin
                    tvalid_s = 1'b0;
                end
            end
            ST_SEND: begin
                tvalid_s = 1'b1;
                if (tvalid_r && axis_tready) begin
                    if (last_beat_s) begin
                        beat_s = '0;
                        if (cont) begin
                            vec_s  = vec;
                            leff_s = LEN_W'(eff_len(int'(len), VEC_BYTES));
                        end else begin
                            state_s  = ST_IDLE;
                            tvalid_s = 1'b0;
                        end
                    end else begin
                        beat_s = beat_r + BEAT_W'(1);
                    end
                end else begin
                    beat_s = beat_r;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                beat_s   = '0;
                tvalid_s = 1'b0;
            end
        endcase
    end

    // The beat about to be presented is selected from next-cycle state so the
    // output registers carry it with no extra latency.
    axis_beat_select #(
        .VEC_BYTES  (VEC_BYTES),
        .AXIS_BYTES (AXIS_BYTES),
        .MSB_FIRST  (MSB_FIRST),
        .LEN_W      (LEN_W),
        .BEAT_W     (BEAT_W)
    ) u_beat_select (
        .vec   (vec_s),
        .leff  (leff_s),
        .beat  (beat_s),
        .tdata (sel_tdata_s),
        .tkeep (sel_tkeep_s),
        .tlast (sel_tlast_s)
    );

    // Control state and snapshot registers.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= ST_IDLE;
            beat_r  <= '0;
            vec_r   <= '0;
            leff_r  <= '0;
            armed_r <= 1'b0;
        end else begin
            state_r <= state_s;
            beat_r  <= beat_s;
            vec_r   <= vec_s;
            leff_r  <= leff_s;
            armed_r <= 1'b1;
        end
    end

    // Registered stream outputs; idle beats are driven to zero.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            tvalid_r <= 1'b0;
            tdata_r  <= '0;
            tkeep_r  <= '0;
            tlast_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            tvalid_r <= tvalid_s;
            tdata_r  <= tvalid_s ? sel_tdata_s : '0;
            tkeep_r  <= tvalid_s ? sel_tkeep_s : '0;
            tlast_r  <= tvalid_s ? sel_tlast_s : 1'b0;
            busy_r   <= (state_s == ST_SEND) ? 1'b1 : 1'b0;
        end
    end

    assign load_ready  = load_ready_s;
    assign axis_tvalid = tvalid_r;
    assign axis_tdata  = tdata_r;
    assign axis_tkeep  = tkeep_r;
    assign axis_tlast  = tlast_r;
    assign busy        = busy_r;

endmodule
